// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous signal over a 2^GATE_LOG2-cycle gate
// and reports the raw count plus the equivalent 32-bit NCO tuning word.
module freq_meter #(
    parameter int GATE_LOG2 = 16
) (
    input  logic        i_clk,
    input  logic        n_rst,
    input  logic        en,
    input  logic        sig_in,
    output logic        busy,
    output logic        meas_valid,
    output logic [31:0] edge_count,
    output logic [31:0] phase_step_est
);
    if (GATE_LOG2 < 2 || GATE_LOG2 > 31) begin : g_bad_gate
        $error("freq_meter: GATE_LOG2 must be in 2..31");
    end

    typedef enum logic {IDLE, GATE} state_t;

    state_t               state_q, state_d;
    logic [2:0]           sync_q;
    logic [GATE_LOG2-1:0] gate_q, gate_d, acc_q, acc_d, sum;
    logic [31:0]          count_q, count_d, est_q, est_d, sum_ext;
    logic                 valid_q, valid_d, pulse, last;

    // sync_q[0..1] form the synchronizer, sync_q[2] is the history flop for edge detection
    assign pulse   = sync_q[1] & ~sync_q[2];
    assign last    = &gate_q;
    assign sum     = acc_q + {{(GATE_LOG2-1){1'b0}}, pulse};
    assign sum_ext = {{(32-GATE_LOG2){1'b0}}, sum};

    always_ff @(posedge i_clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            sync_q  <= '0;
            gate_q  <= '0;
            acc_q   <= '0;
            count_q <= '0;
            est_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[1:0], sig_in};
            gate_q  <= gate_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            est_q   <= est_d;
            valid_q <= valid_d;
        end
    end

    // Both an aborted and a completed window fall back to IDLE when en is low
    always_comb begin
        state_d = en ? GATE : IDLE;
    end

    always_comb begin
        gate_d  = '0;
        acc_d   = '0;
        valid_d = 1'b0;
        count_d = count_q;
        est_d   = est_q;
        if (state_q == GATE) begin
            if (last) begin
                valid_d = 1'b1;
                count_d = sum_ext;
                est_d   = sum_ext << (32 - GATE_LOG2);
            end else if (en) begin
                gate_d = gate_q + 1'b1;
                acc_d  = sum;
            end
        end
    end

    assign busy           = (state_q == GATE);
    assign meas_valid     = valid_q;
    assign edge_count     = count_q;
    assign phase_step_est = est_q;
endmodule
